pulse_chain_seq: RTL and testbench

- Parametrised N-channel optical sync pulse sequencer; successor to the fixed 8-channel Pulse/Delay chain.
- Each channel runs a delay, then a pulse, with a per-channel prescaler.
- Each channel triggers either from the previous channel's completion (chained) or from the common start (parallel).
- Sits between the UART/RAM config path and the optical outputs; reports sequence completion to the Start block.

---
 rtl/pulse_chain_seq.sv | 185 ++++++++++++++++++
 tb/tb_pulse_chain_seq.sv | 138 +++++++++++++
 2 files changed

// File: rtl/pulse_chain_seq.sv
// rtl/pulse_chain_seq.sv - N-channel delay/pulse sequencer with chained or parallel triggering.
// Optional repeat-count feature enabled by defining PULSE_CHAIN_SEQ_REPEAT_EN.
module pulse_chain_seq #(
  parameter int N_CH  = 8,
  parameter int CNT_W = 18,
  parameter int PRE_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_ch,
  input  logic [1:0]       cfg_sel,
  input  logic [CNT_W-1:0] cfg_data,
  input  logic             start,
  input  logic             abort,
  output logic [N_CH-1:0]  ch_out,
  output logic             busy,
  output logic             seq_done
);

  typedef enum logic [1:0] {IDLE, DELAY, PULSE} st_t;

  logic [CNT_W-1:0] sh_dly [N_CH];
  logic [CNT_W-1:0] sh_wid [N_CH];
  logic [PRE_W-1:0] sh_pre [N_CH];
  logic [N_CH-1:0]  sh_en, sh_mode;
  logic [CNT_W-1:0] wk_dly [N_CH];
  logic [CNT_W-1:0] wk_wid [N_CH];
  logic [PRE_W-1:0] wk_pre [N_CH];
  logic [N_CH-1:0]  wk_en, wk_mode;
  logic [CNT_W-1:0] e_dly [N_CH];
  logic [CNT_W-1:0] e_wid [N_CH];
  logic [PRE_W-1:0] e_pre [N_CH];
  logic [N_CH-1:0]  e_en, e_mode;

  st_t              st_q [N_CH];
  st_t              st_d [N_CH];
  logic [CNT_W-1:0] tick_q [N_CH];
  logic [CNT_W-1:0] tick_d [N_CH];
  logic [PRE_W-1:0] pre_q [N_CH];
  logic [PRE_W-1:0] pre_d [N_CH];
  logic [N_CH-1:0]  out_d, done, trig, chain_q, chain_d, flags, flags_d;

  logic abort_now, all_done, accept, rerun, seq_end, run_start, more_runs;

  assign abort_now = abort && busy;
  assign all_done  = &flags;
  assign accept    = start && !busy && !abort;
  assign rerun     = busy && !abort && all_done && more_runs;
  assign seq_end   = busy && !abort && all_done && !more_runs;
  assign run_start = accept || rerun;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_CH; k++) begin
        sh_dly[k] <= '0; sh_wid[k] <= '0; sh_pre[k] <= '0;
        wk_dly[k] <= '0; wk_wid[k] <= '0; wk_pre[k] <= '0;
      end
      sh_en <= '0; sh_mode <= '0; wk_en <= '0; wk_mode <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (cfg_we && cfg_ch == 4'(k)) begin
          case (cfg_sel)
            2'd0: sh_dly[k] <= cfg_data;
            2'd1: sh_wid[k] <= cfg_data;
            2'd2: begin
              sh_en[k]   <= cfg_data[PRE_W+1];
              sh_mode[k] <= cfg_data[PRE_W];
              sh_pre[k]  <= cfg_data[PRE_W-1:0];
            end
            default: ;
          endcase
        end
        if (accept) begin
          wk_dly[k] <= sh_dly[k]; wk_wid[k] <= sh_wid[k]; wk_pre[k] <= sh_pre[k];
        end
      end
      if (accept) begin
        wk_en <= sh_en; wk_mode <= sh_mode;
      end
    end
  end

`ifdef PULSE_CHAIN_SEQ_REPEAT_EN
  logic [15:0] rep_sh, rep_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_sh  <= '0;
      rep_cnt <= '0;
    end else begin
      if (cfg_we && cfg_sel == 2'd3) rep_sh <= cfg_data[15:0];
      if (accept) rep_cnt <= rep_sh;
      else if (rerun) rep_cnt <= rep_cnt - 16'd1;
    end
  end
  assign more_runs = (rep_cnt != 16'd0);
`else
  assign more_runs = 1'b0;
`endif

  // Shadow config takes effect at the very edge a run is accepted.
  always_comb begin
    e_en   = accept ? sh_en : wk_en;
    e_mode = accept ? sh_mode : wk_mode;
    for (int k = 0; k < N_CH; k++) begin
      e_dly[k] = accept ? sh_dly[k] : wk_dly[k];
      e_wid[k] = accept ? sh_wid[k] : wk_wid[k];
      e_pre[k] = accept ? sh_pre[k] : wk_pre[k];
    end
  end

  always_comb begin
    done    = '0;
    trig    = '0;
    chain_d = '0;
    out_d   = ch_out;
    for (int k = 0; k < N_CH; k++) begin
      st_d[k]   = st_q[k];
      tick_d[k] = tick_q[k];
      pre_d[k]  = pre_q[k];
      trig[k]   = (e_mode[k] || k == 0) ? run_start : (busy && !run_start && chain_q[k]);
      case (st_q[k])
        IDLE: if (trig[k]) begin
          if (!e_en[k]) done[k] = 1'b1;
          else if (run_start || !flags[k]) begin
            pre_d[k] = e_pre[k];
            if (e_dly[k] != '0) begin
              st_d[k] = DELAY; tick_d[k] = e_dly[k];
            end else if (e_wid[k] != '0) begin
              st_d[k] = PULSE; tick_d[k] = e_wid[k]; out_d[k] = 1'b1;
            end else done[k] = 1'b1;
          end
        end
        DELAY: if (pre_q[k] != '0) pre_d[k] = pre_q[k] - PRE_W'(1);
        else begin
          pre_d[k] = wk_pre[k];
          if (tick_q[k] != CNT_W'(1)) tick_d[k] = tick_q[k] - CNT_W'(1);
          else if (wk_wid[k] != '0) begin
            st_d[k] = PULSE; tick_d[k] = wk_wid[k]; out_d[k] = 1'b1;
          end else begin
            st_d[k] = IDLE; done[k] = 1'b1;
          end
        end
        PULSE: if (pre_q[k] != '0) pre_d[k] = pre_q[k] - PRE_W'(1);
        else begin
          pre_d[k] = wk_pre[k];
          if (tick_q[k] != CNT_W'(1)) tick_d[k] = tick_q[k] - CNT_W'(1);
          else begin
            st_d[k] = IDLE; out_d[k] = 1'b0; done[k] = 1'b1;
          end
        end
        default: st_d[k] = IDLE;
      endcase
    end
    for (int k = 1; k < N_CH; k++) chain_d[k] = done[k-1];
    // Disabled channels count as complete from the start of each run.
    flags_d = run_start ? (~e_en | done) : (flags | done);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_CH; k++) begin
        st_q[k] <= IDLE; tick_q[k] <= '0; pre_q[k] <= '0;
      end
      ch_out <= '0; chain_q <= '0; flags <= '0; busy <= 1'b0; seq_done <= 1'b0;
    end else if (abort_now) begin
      for (int k = 0; k < N_CH; k++) st_q[k] <= IDLE;
      ch_out <= '0; chain_q <= '0; flags <= '0; busy <= 1'b0; seq_done <= 1'b0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        st_q[k] <= st_d[k]; tick_q[k] <= tick_d[k]; pre_q[k] <= pre_d[k];
      end
      ch_out   <= out_d;
      seq_done <= seq_end;
      if (seq_end) begin
        busy <= 1'b0; flags <= '0; chain_q <= '0;
      end else begin
        flags   <= flags_d;
        chain_q <= chain_d;
        if (run_start) busy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pulse_chain_seq.sv
// tb/tb_pulse_chain_seq.sv - directed self-checking bench for pulse_chain_seq.
module tb_pulse_chain_seq;
  localparam int N_CH = 8, CNT_W = 18, PRE_W = 5;

  logic clk = 1'b0;
  logic rst, cfg_we, start, abort, busy, seq_done;
  logic [3:0] cfg_ch;
  logic [1:0] cfg_sel;
  logic [CNT_W-1:0] cfg_data;
  logic [N_CH-1:0] ch_out;
  int checks = 0;
  int errors = 0;

  pulse_chain_seq #(.N_CH(N_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .start(start), .abort(abort), .ch_out(ch_out),
    .busy(busy), .seq_done(seq_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic wr(input int ch, input int sel, input int data);
    cfg_we = 1'b1; cfg_ch = ch[3:0]; cfg_sel = sel[1:0]; cfg_data = data[CNT_W-1:0];
    step();
    cfg_we = 1'b0;
  endtask

  function automatic int ctrl(input int en, input int mode, input int pre);
    return (en << (PRE_W + 1)) | (mode << PRE_W) | pre;
  endfunction

  task automatic chk3(input string tag, input int i, input int o, input int sd, input int b);
    check($sformatf("%s out i=%0d", tag, i), 32'(ch_out), o);
    check($sformatf("%s done i=%0d", tag, i), 32'(seq_done), sd);
    check($sformatf("%s busy i=%0d", tag, i), 32'(busy), b);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
    start = 1'b0; abort = 1'b0;
    step(); step();
    rst = 1'b0;
    chk3("reset", 0, 0, 0, 0);

    // No config: all disabled, completes one cycle after acceptance.
    start = 1'b1;
    for (int i = 0; i <= 2; i++) begin
      step(); start = 1'b0;
      chk3("empty", i, 0, int'(i == 1), int'(i == 0));
    end

    wr(0, 0, 3); wr(0, 1, 5); wr(0, 2, ctrl(1, 0, 0));
    start = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      step(); start = 1'b0;
      chk3("single", i, int'(i >= 3 && i < 8), int'(i == 9), int'(i < 9));
    end

    wr(0, 0, 0); wr(0, 1, 2); wr(1, 0, 1); wr(1, 1, 1); wr(1, 2, ctrl(1, 0, 1));
    start = 1'b1;
    for (int i = 0; i <= 9; i++) begin
      step(); start = 1'b0;
      chk3("chain", i, (i < 2 ? 1 : 0) | ((i == 5 || i == 6) ? 2 : 0), int'(i == 8), int'(i < 8));
    end

    wr(0, 1, 10); wr(1, 2, 0); wr(2, 0, 4); wr(2, 1, 1); wr(2, 2, ctrl(1, 1, 0));
    start = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      step(); start = 1'b0;
      chk3("parallel", i, (i < 10 ? 1 : 0) | (i == 4 ? 4 : 0), int'(i == 11), int'(i < 11));
    end

    // Mid-run width write, then abort at T+2.
    wr(2, 2, 0);
    start = 1'b1;
    step(); start = 1'b0;
    chk3("abort", 0, 1, 0, 1);
    wr(0, 1, 3);
    chk3("abort", 1, 1, 0, 1);
    abort = 1'b1;
    step(); abort = 1'b0;
    chk3("abort", 2, 0, 0, 0);
    for (int i = 3; i <= 5; i++) begin
      step();
      chk3("abort", i, 0, 0, 0);
    end
    // New width takes effect; start held while busy is ignored.
    start = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      step();
      if (i == 2) start = 1'b0;
      chk3("rerun", i, int'(i < 3), int'(i == 4), int'(i < 4));
    end

    wr(0, 0, 1); wr(0, 1, 1); wr(0, 2, ctrl(1, 0, 0)); wr(5, 3, 2);
    start = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      step(); start = 1'b0;
`ifdef PULSE_CHAIN_SEQ_REPEAT_EN
      chk3("repeat", i, int'(i == 1 || i == 4 || i == 7), int'(i == 9), int'(i < 9));
`else
      chk3("repeat", i, int'(i == 1), int'(i == 3), int'(i < 3));
`endif
    end

    // Reset mid-run clears state and shadow config.
    start = 1'b1;
    step(); start = 1'b0;
    step();
    chk3("pre_rst", 1, 1, 0, 1);
    rst = 1'b1;
    #2;
    chk3("async_rst", 0, 0, 0, 0);
    rst = 1'b0;
    start = 1'b1;
    for (int i = 0; i <= 1; i++) begin
      step(); start = 1'b0;
      chk3("post_rst", i, 0, int'(i == 1), int'(i == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
